comp_result_tracker: RTL and testbench
======================================

# comp_result_tracker

Sequential stage downstream of the 2-bit magnitude comparator `comp`. It samples the comparator's one-hot result flags (`a_grt_b`, `a_less_b`, `eq`) under a valid strobe and keeps a saturating tally of each outcome. It detects a run of consecutive equal results ("lock") and flags illegal flag encodings as a sticky fault. Downstream control logic reads its registered status; it applies no backpressure to the comparator.

## Interface
- `CNT_W`, 8: width of each outcome counter.
- `LOCK_LEN`, 4: consecutive valid `eq` samples required to assert `locked`. Must be ≥1.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, **synchronous, active-high**. Highest priority.
- `clr`  in  1  synchronous soft clear; same effect as `rst`. Priority over `in_valid`.
- `in_valid`  in  1  comparator flags are valid this cycle.
- `a_grt_b`  in  1  comparator flag: a > b.
- `a_less_b`  in  1  comparator flag: a < b.
- `eq`  in  1  comparator flag: a == b.
- `out_valid`  out  1  one-cycle pulse, one cycle after each accepted legal sample.
- `last_result`  out  2  encoding of the last accepted legal sample: 00 none, 01 gt, 10 lt, 11 eq.
- `gt_cnt`, `lt_cnt`, `eq_cnt`  out  CNT_W  saturating outcome counters.
- `locked`  out  1  eq-run lock status.
- `fault`  out  1  sticky illegal-encoding flag.
- `state`  out  2  FSM state, for debug.

## Operation
- **Legal sample:** `in_valid`=1 and exactly one of {`a_grt_b`, `a_less_b`, `eq`} is high.
- **Illegal sample:** `in_valid`=1 and the flags are 000, 011, 101, 110 or 111.
- **FSM states:** IDLE=0, TRACK=1, LOCKED=2, FAULT=3.
  - IDLE: a legal sample moves to TRACK, or to LOCKED if `LOCK_LEN`=1. An illegal sample moves to FAULT.
  - TRACK: an `eq` sample increments `streak`. When `streak` reaches `LOCK_LEN`, move to LOCKED. A `gt` or `lt` sample resets `streak` to 0. An illegal sample moves to FAULT.
  - LOCKED: an `eq` sample keeps the state. A `gt` or `lt` sample moves to TRACK with `streak`=0. An illegal sample moves to FAULT.
  - FAULT: absorbing. All samples are ignored; counters, `last_result` and `streak` are frozen, and `out_valid` stays 0. Only `rst` or `clr` exits.
- Cycles with `in_valid`=0 change nothing, and they do not break a streak.
- **Counters:** each legal sample increments the matching counter by 1. A counter saturates at 2^CNT_W−1 and does not wrap.
- **Streak counter:** internal, width `$clog2(LOCK_LEN+1)`. It saturates at `LOCK_LEN`.
- **Decoded outputs:** `locked` = (state==LOCKED); `fault` = (state==FAULT).
- **Reset / clear:** `rst` or `clr` sets state=IDLE and zeroes all counters, `streak`, `last_result` and `out_valid`. This applies from any state, including mid-LOCKED. A sample presented in the same cycle as `clr` is dropped.

## Timing
- Every output is registered. The effect of a sample accepted at edge t is visible after edge t (latency 1).
- `locked` rises one cycle after the `LOCK_LEN`-th consecutive `eq` sample. It falls one cycle after the first `gt` or `lt` sample.
- `fault` rises one cycle after the illegal sample. That sample is not counted and produces no `out_valid`.
- **Back-to-back samples:** every cycle is accepted. Throughput is one sample per clock.
- **Reset values:** every output is 0 and `state`=IDLE.

## Structure
- Shared package `comp_pkg` holds:
  - the state enum typedef (IDLE/TRACK/LOCKED/FAULT);
  - the `last_result` encoding constants RES_NONE/GT/LT/EQ;
  - the 2-bit comparator width constant, shared with `comp`.
- One natural sub-module: `sat_counter`, parameterised by width, with inc and clr inputs and saturation. Instantiate it three times for the outcome counters; the streak counter reuses it.
- FSM and legality decode stay in the top module.

## Test plan
Use `CNT_W`=4 and `LOCK_LEN`=3 unless stated otherwise.
- **Reset:** hold `rst` for 2 cycles → every output is 0 and `state`=IDLE. With `in_valid`=0 and no samples, the outputs stay 0.
- **Exhaustive sweep:** drive `comp` over all 16 (a,b) pairs, one per cycle, with `in_valid`=1 → `gt_cnt`=6, `lt_cnt`=6, `eq_cnt`=4, `locked`=0, and 16 `out_valid` pulses.
- **Lock with gaps:** send eq, idle, eq, idle, idle, eq → `locked`=1 in the cycle after the third eq. A following gt sample → `locked`=0 the next cycle and `state`=TRACK.
- **Illegal encoding:** after 2 legal gt samples, send flags 110 → `fault`=1 next cycle and `gt_cnt` stays 2. Further samples do not change the counters. Then assert `clr` → `state`=IDLE and all counters 0.
- **Saturation:** send 20 consecutive lt samples → `lt_cnt`=15 and it holds there. The other counters stay 0.
- **Priority and reset mid-operation:** `clr` with a legal eq sample in the same cycle → sample dropped and `eq_cnt`=0. Assert `rst` while LOCKED with `eq_cnt`=5 → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared definitions for the 2-bit comparator and its downstream result tracker.
package comp_pkg;

  // Operand width of the magnitude comparator feeding the tracker.
  localparam int unsigned COMP_W = 2;

  // Tracker FSM states; encoding is visible on the debug state port.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StTrack  = 2'd1,
    StLocked = 2'd2,
    StFault  = 2'd3
  } state_e;

  // Encoding of the last accepted legal comparator result.
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_GT   = 2'b01;
  localparam logic [1:0] RES_LT   = 2'b10;
  localparam logic [1:0] RES_EQ   = 2'b11;

endpackage

// File: rtl/comp_result_tracker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned      Width  = 8,
  parameter logic [Width-1:0] MaxVal = {Width{1'b1}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  // Next count: clear, else increment unless already at the ceiling.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MaxVal)) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/comp_result_tracker.sv
// Tallies comparator outcomes, detects runs of equal results and latches illegal flag encodings.
module comp_result_tracker
  import comp_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             a_grt_b,
  input  logic             a_less_b,
  input  logic             eq,
  output logic             out_valid,
  output logic [1:0]       last_result,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       state
);

  localparam int unsigned StreakW = $clog2(LOCK_LEN + 1);
  localparam logic [StreakW-1:0] StreakMax  = StreakW'(LOCK_LEN);
  // Streak value that, with one more eq, completes the run.
  localparam logic [StreakW-1:0] StreakLast = StreakW'(LOCK_LEN - 1);

  state_e             state_q, state_d;
  logic [1:0]         last_result_q, last_result_d;
  logic               out_valid_q, locked_q, fault_q;
  logic [StreakW-1:0] streak;
  logic               clear, legal, active, accept, illegal_in;
  logic               streak_inc, streak_rst;
  logic [1:0]         res_code;

  assign clear = rst | clr;

  // Legality decode: exactly one flag high, and its result encoding.
  always_comb begin
    legal    = 1'b0;
    res_code = RES_NONE;
    unique case ({eq, a_less_b, a_grt_b})
      3'b001:  begin legal = 1'b1; res_code = RES_GT; end
      3'b010:  begin legal = 1'b1; res_code = RES_LT; end
      3'b100:  begin legal = 1'b1; res_code = RES_EQ; end
      default: begin legal = 1'b0; res_code = RES_NONE; end
    endcase
  end

  // FAULT is absorbing, so samples there are neither accepted nor re-flagged.
  assign active     = (state_q != StFault);
  assign accept     = in_valid & active & legal;
  assign illegal_in = in_valid & active & ~legal;

  // Next-state and streak control.
  always_comb begin
    state_d       = state_q;
    last_result_d = last_result_q;
    streak_inc    = 1'b0;
    streak_rst    = 1'b0;
    if (illegal_in) begin
      state_d = StFault;
    end else if (accept) begin
      last_result_d = res_code;
      unique case (state_q)
        StIdle, StTrack: begin
          if (eq) begin
            streak_inc = 1'b1;
            state_d    = (streak >= StreakLast) ? StLocked : StTrack;
          end else begin
            streak_rst = 1'b1;
            state_d    = StTrack;
          end
        end
        StLocked: begin
          if (eq) begin
            streak_inc = 1'b1;
          end else begin
            streak_rst = 1'b1;
            state_d    = StTrack;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State and status registers; rst and clr both return to IDLE.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= StIdle;
      last_result_q <= RES_NONE;
      out_valid_q   <= 1'b0;
      locked_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_result_q <= last_result_d;
      out_valid_q   <= accept;
      locked_q      <= (state_d == StLocked);
      fault_q       <= (state_d == StFault);
    end
  end

  sat_counter #(.Width(CNT_W)) u_gt_cnt (
    .clk   (clk),
    .clr   (clear),
    .inc   (accept & a_grt_b),
    .count (gt_cnt)
  );

  sat_counter #(.Width(CNT_W)) u_lt_cnt (
    .clk   (clk),
    .clr   (clear),
    .inc   (accept & a_less_b),
    .count (lt_cnt)
  );

  sat_counter #(.Width(CNT_W)) u_eq_cnt (
    .clk   (clk),
    .clr   (clear),
    .inc   (accept & eq),
    .count (eq_cnt)
  );

  sat_counter #(.Width(StreakW), .MaxVal(StreakMax)) u_streak (
    .clk   (clk),
    .clr   (clear | streak_rst),
    .inc   (streak_inc),
    .count (streak)
  );

  assign out_valid   = out_valid_q;
  assign last_result = last_result_q;
  assign locked      = locked_q;
  assign fault       = fault_q;
  assign state       = state_q;

endmodule

// File: tb/tb_comp_result_tracker.sv
// Directed and randomized bench for comp_result_tracker against an outcome-level model.
module tb_comp_result_tracker;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned LOCK_LEN = 3;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, clr, in_valid, a_grt_b, a_less_b, eq;
  logic             out_valid, locked, fault;
  logic [1:0]       last_result, state;
  logic [CNT_W-1:0] gt_cnt, lt_cnt, eq_cnt;

  int checks = 0;
  int errors = 0;

  // Model: outcome tallies, length of the current eq run, and a fault latch.
  int m_gt, m_lt, m_eq, m_run, m_last;
  bit m_any, m_fault, m_ov;

  comp_result_tracker #(.CNT_W(CNT_W), .LOCK_LEN(LOCK_LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .in_valid    (in_valid),
    .a_grt_b     (a_grt_b),
    .a_less_b    (a_less_b),
    .eq          (eq),
    .out_valid   (out_valid),
    .last_result (last_result),
    .gt_cnt      (gt_cnt),
    .lt_cnt      (lt_cnt),
    .eq_cnt      (eq_cnt),
    .locked      (locked),
    .fault       (fault),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gt = 0; m_lt = 0; m_eq = 0; m_run = 0; m_last = 0;
    m_any = 0; m_fault = 0; m_ov = 0;
  endtask

  task automatic model_step(input bit r, c, v, g, l, e);
    m_ov = 0;
    if (r || c) begin
      model_reset();
    end else if (v && !m_fault) begin
      if (int'(g) + int'(l) + int'(e) == 1) begin
        m_ov  = 1;
        m_any = 1;
        if (g) begin m_gt = (m_gt < CNT_MAX) ? m_gt + 1 : m_gt; m_run = 0; m_last = 1; end
        if (l) begin m_lt = (m_lt < CNT_MAX) ? m_lt + 1 : m_lt; m_run = 0; m_last = 2; end
        if (e) begin m_eq = (m_eq < CNT_MAX) ? m_eq + 1 : m_eq; m_run++;     m_last = 3; end
      end else begin
        m_fault = 1;
      end
    end
  endtask

  task automatic check_all();
    bit exp_lock;
    int exp_state;
    exp_lock  = !m_fault && (m_run >= LOCK_LEN);
    exp_state = m_fault ? 3 : exp_lock ? 2 : m_any ? 1 : 0;
    chk("out_valid", out_valid, m_ov);
    chk("last_result", last_result, m_last);
    chk("gt_cnt", gt_cnt, m_gt);
    chk("lt_cnt", lt_cnt, m_lt);
    chk("eq_cnt", eq_cnt, m_eq);
    chk("locked", locked, exp_lock);
    chk("fault", fault, m_fault);
    chk("state", state, exp_state);
  endtask

  // One clock: drive inputs, advance the model at the edge, check just after it.
  task automatic step(input bit r, c, v, g, l, e);
    @(negedge clk);
    rst = r; clr = c; in_valid = v; a_grt_b = g; a_less_b = l; eq = e;
    @(posedge clk);
    model_step(r, c, v, g, l, e);
    #1;
    check_all();
  endtask

  task automatic idle();      step(0, 0, 0, 0, 0, 0); endtask
  task automatic send_gt();   step(0, 0, 1, 1, 0, 0); endtask
  task automatic send_lt();   step(0, 0, 1, 0, 1, 0); endtask
  task automatic send_eq();   step(0, 0, 1, 0, 0, 1); endtask
  task automatic soft_clr();  step(0, 1, 0, 0, 0, 0); endtask

  initial begin
    int pulses;
    logic [3:0] r;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; a_grt_b = 1'b0; a_less_b = 1'b0; eq = 1'b0;
    model_reset();

    // Reset held two cycles, then quiet cycles leave everything at zero.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_state", state, 0);
    repeat (3) idle();

    // Sweep every 2-bit operand pair through a behavioural comparator.
    pulses = 0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        step(0, 0, 1, a > b, a < b, a == b);
        if (out_valid) pulses++;
      end
    end
    chk("sweep_pulses", pulses, 16);
    chk("sweep_gt", gt_cnt, 6);
    chk("sweep_lt", lt_cnt, 6);
    chk("sweep_eq", eq_cnt, 4);
    chk("sweep_locked", locked, 0);

    // Lock across idle gaps, then release on a gt sample.
    soft_clr();
    send_eq(); idle(); send_eq(); idle(); idle();
    chk("lock_not_yet", locked, 0);
    send_eq();
    chk("lock_rise", locked, 1);
    send_gt();
    chk("lock_fall", locked, 0);
    chk("lock_fall_state", state, 1);

    // Illegal encoding 110 latches fault and freezes the tallies.
    soft_clr();
    send_gt(); send_gt();
    step(0, 0, 1, 1, 1, 0);
    chk("fault_rise", fault, 1);
    chk("fault_gt_held", gt_cnt, 2);
    send_eq(); send_lt(); step(0, 0, 1, 0, 0, 0);
    chk("fault_frozen_eq", eq_cnt, 0);
    soft_clr();
    chk("fault_cleared", state, 0);

    // Saturation of the lt tally.
    repeat (20) send_lt();
    chk("sat_lt", lt_cnt, CNT_MAX);

    // clr beats a same-cycle sample; rst mid-LOCKED clears everything.
    step(0, 1, 1, 0, 0, 1);
    chk("clr_drop_eq", eq_cnt, 0);
    repeat (5) send_eq();
    chk("pre_rst_locked", locked, 1);
    chk("pre_rst_eq", eq_cnt, 5);
    step(1, 0, 1, 0, 0, 1);
    chk("rst_locked", locked, 0);
    chk("rst_eq", eq_cnt, 0);

    // Randomized traffic with occasional illegal flags and clears.
    for (int i = 0; i < 400; i++) begin
      bit rr, cc, vv, gg, ll, ee;
      rr = ($urandom_range(0, 59) == 0);
      cc = ($urandom_range(0, 29) == 0);
      vv = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        r = 4'($urandom_range(0, 7));
        gg = r[0]; ll = r[1]; ee = r[2];
      end else begin
        case ($urandom_range(0, 2))
          0:       begin gg = 1; ll = 0; ee = 0; end
          1:       begin gg = 0; ll = 1; ee = 0; end
          default: begin gg = 0; ll = 0; ee = 1; end
        endcase
      end
      step(rr, cc, vv, gg, ll, ee);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
